// File: rtl/msrv32_pkg.sv
// Shared encodings for the machine-mode trap controller: FSM states, cause codes, PC select.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package msrv32_pkg;

  // Machine-control FSM states
  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } mc_state_t;

  // PC source select driven to the fetch stage
  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_EPC  = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  // Exception cause codes (mcause with interrupt bit clear)
  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  // Interrupt cause codes (mcause with interrupt bit set)
  localparam logic [3:0] CAUSE_INT_SOFTWARE = 4'd3;
  localparam logic [3:0] CAUSE_INT_TIMER    = 4'd7;
  localparam logic [3:0] CAUSE_INT_EXTERNAL = 4'd11;

  // SYSTEM instruction decode fields
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;
  localparam logic [2:0] F3_PRIV     = 3'b000;
  localparam logic [6:0] F7_ECALL    = 7'b0000000;
  localparam logic [6:0] F7_MRET     = 7'b0011000;
  localparam logic [4:0] RS2_ECALL   = 5'b00000;
  localparam logic [4:0] RS2_EBREAK  = 5'b00001;
  localparam logic [4:0] RS2_MRET    = 5'b00010;

  // True for the causes that report a misaligned access
  function automatic logic cause_is_misaligned(input logic [3:0] c);
    return (c == CAUSE_INSTR_MISALIGNED) || (c == CAUSE_LOAD_MISALIGNED) ||
           (c == CAUSE_STORE_MISALIGNED);
  endfunction

endpackage

// File: rtl/msrv32_trap_decode.sv
// SYSTEM-instruction decode plus exception/interrupt priority encoding.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the FSM decides whether the request is acted upon.
module msrv32_trap_decode
  import msrv32_pkg::*;
(
  input  logic       illegal_instr_i,
  input  logic       misaligned_instr_i,
  input  logic       misaligned_load_i,
  input  logic       misaligned_store_i,
  input  logic [4:0] opcode_6_2_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic [4:0] rd_addr_i,
  input  logic       mie_i,
  input  logic       meie_i,
  input  logic       mtie_i,
  input  logic       msie_i,
  input  logic       meip_i,
  input  logic       mtip_i,
  input  logic       msip_i,
  output logic       trap_req_o,
  output logic       is_int_o,
  output logic [3:0] cause_o,
  output logic       is_misaligned_o,
  output logic       mret_o
);

  logic is_system;
  logic is_ecall;
  logic is_ebreak;
  logic is_mret;
  logic any_exc;
  logic ext_pend;
  logic sw_pend;
  logic tmr_pend;
  logic int_take;

  assign is_system = (opcode_6_2_i == OPC_SYSTEM) && (funct3_i == F3_PRIV) &&
                     (rs1_addr_i == 5'd0) && (rd_addr_i == 5'd0);
  assign is_ecall  = is_system && (funct7_i == F7_ECALL) && (rs2_addr_i == RS2_ECALL);
  assign is_ebreak = is_system && (funct7_i == F7_ECALL) && (rs2_addr_i == RS2_EBREAK);
  assign is_mret   = is_system && (funct7_i == F7_MRET)  && (rs2_addr_i == RS2_MRET);

  assign any_exc = illegal_instr_i | misaligned_instr_i | is_ecall | is_ebreak |
                   misaligned_load_i | misaligned_store_i;

  // An interrupt is only taken when globally enabled and a source is both enabled and pending
  assign ext_pend = meie_i & meip_i;
  assign sw_pend  = msie_i & msip_i;
  assign tmr_pend = mtie_i & mtip_i;
  assign int_take = mie_i & (ext_pend | sw_pend | tmr_pend);

  assign trap_req_o = any_exc | int_take;
  // mret is reported raw; a concurrent trap request overrides it in the FSM
  assign mret_o     = is_mret;

  // Priority encode: exceptions first (fixed order), then interrupts ext > sw > timer
  always_comb begin
    cause_o  = CAUSE_INSTR_MISALIGNED;
    is_int_o = 1'b0;
    if (illegal_instr_i) begin
      cause_o = CAUSE_ILLEGAL_INSTR;
    end else if (misaligned_instr_i) begin
      cause_o = CAUSE_INSTR_MISALIGNED;
    end else if (is_ecall) begin
      cause_o = CAUSE_ECALL_M;
    end else if (is_ebreak) begin
      cause_o = CAUSE_BREAKPOINT;
    end else if (misaligned_load_i) begin
      cause_o = CAUSE_LOAD_MISALIGNED;
    end else if (misaligned_store_i) begin
      cause_o = CAUSE_STORE_MISALIGNED;
    end else if (int_take) begin
      is_int_o = 1'b1;
      if (ext_pend) begin
        cause_o = CAUSE_INT_EXTERNAL;
      end else if (sw_pend) begin
        cause_o = CAUSE_INT_SOFTWARE;
      end else begin
        cause_o = CAUSE_INT_TIMER;
      end
    end
  end

  // Interrupt cause numbers overlap exception ones, so qualify with the exception path
  assign is_misaligned_o = any_exc & cause_is_misaligned(cause_o);

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer: FSM driving PC select, flush and CSR strobes.
// Latency: trap/mret seen in OPERATING takes effect the next cycle; trap states last one cycle.
// Backpressure: none; events arriving in TRAP_TAKEN/TRAP_RETURN are ignored.
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       misaligned_exception_out,
  output logic [3:0] cause_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out
);

  mc_state_t  state_q, state_d;
  logic [3:0] cause_q;
  logic       i_or_e_q;
  logic       misaligned_q;
  logic       trap_req;
  logic       is_int;
  logic [3:0] cause;
  logic       is_misaligned;
  logic       mret;
  logic       take_trap;

  msrv32_trap_decode u_trap_decode (
    .illegal_instr_i    (illegal_instr_in),
    .misaligned_instr_i (misaligned_instr_in),
    .misaligned_load_i  (misaligned_load_in),
    .misaligned_store_i (misaligned_store_in),
    .opcode_6_2_i       (opcode_6_2_in),
    .funct3_i           (funct3_in),
    .funct7_i           (funct7_in),
    .rs1_addr_i         (rs1_addr_in),
    .rs2_addr_i         (rs2_addr_in),
    .rd_addr_i          (rd_addr_in),
    .mie_i              (mie_in),
    .meie_i             (meie_in),
    .mtie_i             (mtie_in),
    .msie_i             (msie_in),
    .meip_i             (meip_in),
    .mtip_i             (mtip_in),
    .msip_i             (msip_in),
    .trap_req_o         (trap_req),
    .is_int_o           (is_int),
    .cause_o            (cause),
    .is_misaligned_o    (is_misaligned),
    .mret_o             (mret)
  );

  assign take_trap = (state_q == ST_OPERATING) && trap_req;

  // State register; reset forces RESET asynchronously, even mid-trap
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Trap information is captured only on entry to TRAP_TAKEN and held until the next trap
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cause_q      <= 4'd0;
      i_or_e_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (take_trap) begin
      cause_q      <= cause;
      i_or_e_q     <= is_int;
      misaligned_q <= is_misaligned;
    end
  end

  // Next-state and Moore outputs; traps beat mret, trap states always fall back to OPERATING
  always_comb begin
    state_d         = state_q;
    pc_src_out      = PC_BOOT;
    flush_out       = 1'b1;
    instret_inc_out = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_OPERATING;
      end
      ST_OPERATING: begin
        pc_src_out      = PC_NEXT;
        flush_out       = 1'b0;
        instret_inc_out = 1'b1;
        if (trap_req) begin
          state_d = ST_TRAP_TAKEN;
        end else if (mret) begin
          state_d = ST_TRAP_RETURN;
        end
      end
      ST_TRAP_TAKEN: begin
        pc_src_out    = PC_TRAP;
        set_epc_out   = 1'b1;
        set_cause_out = 1'b1;
        mie_clear_out = 1'b1;
        state_d       = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        mie_set_out = 1'b1;
        state_d     = ST_OPERATING;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign cause_out                = cause_q;
  assign i_or_e_out               = i_or_e_q;
  assign misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed bench for the machine-mode trap controller.
// Latency: checks one cycle after each stimulus edge.
// Backpressure: n/a.
module tb_msrv32_machine_control;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
  logic [4:0] opcode_6_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic       i_or_e_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out;
  logic       instret_inc_out, misaligned_exception_out, flush_out;
  logic [3:0] cause_out;
  logic [1:0] pc_src_out;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  msrv32_machine_control dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .illegal_instr_in         (illegal_instr_in),
    .misaligned_instr_in      (misaligned_instr_in),
    .misaligned_load_in       (misaligned_load_in),
    .misaligned_store_in      (misaligned_store_in),
    .opcode_6_2_in            (opcode_6_2_in),
    .funct3_in                (funct3_in),
    .funct7_in                (funct7_in),
    .rs1_addr_in              (rs1_addr_in),
    .rs2_addr_in              (rs2_addr_in),
    .rd_addr_in               (rd_addr_in),
    .mie_in                   (mie_in),
    .meie_in                  (meie_in),
    .mtie_in                  (mtie_in),
    .msie_in                  (msie_in),
    .meip_in                  (meip_in),
    .mtip_in                  (mtip_in),
    .msip_in                  (msip_in),
    .i_or_e_out               (i_or_e_out),
    .set_cause_out            (set_cause_out),
    .set_epc_out              (set_epc_out),
    .mie_clear_out            (mie_clear_out),
    .mie_set_out              (mie_set_out),
    .instret_inc_out          (instret_inc_out),
    .misaligned_exception_out (misaligned_exception_out),
    .cause_out                (cause_out),
    .pc_src_out               (pc_src_out),
    .flush_out                (flush_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against hand-computed values
  task automatic chk_all(input string tag, input logic [1:0] pc, input logic fl,
                         input logic ir, input logic epc, input logic scause,
                         input logic mclr, input logic mset, input logic [3:0] cs,
                         input logic ioe, input logic mis);
    chk({tag, ".pc_src"},    {30'd0, pc_src_out}, {30'd0, pc});
    chk({tag, ".flush"},     {31'd0, flush_out}, {31'd0, fl});
    chk({tag, ".instret"},   {31'd0, instret_inc_out}, {31'd0, ir});
    chk({tag, ".set_epc"},   {31'd0, set_epc_out}, {31'd0, epc});
    chk({tag, ".set_cause"}, {31'd0, set_cause_out}, {31'd0, scause});
    chk({tag, ".mie_clear"}, {31'd0, mie_clear_out}, {31'd0, mclr});
    chk({tag, ".mie_set"},   {31'd0, mie_set_out}, {31'd0, mset});
    chk({tag, ".cause"},     {28'd0, cause_out}, {28'd0, cs});
    chk({tag, ".i_or_e"},    {31'd0, i_or_e_out}, {31'd0, ioe});
    chk({tag, ".misalign"},  {31'd0, misaligned_exception_out}, {31'd0, mis});
  endtask

  task automatic clear_inputs();
    illegal_instr_in = 0; misaligned_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0;
    opcode_6_2_in = 5'd0; funct3_in = 3'd0; funct7_in = 7'd0;
    rs1_addr_in = 5'd0; rs2_addr_in = 5'd0; rd_addr_in = 5'd0;
    mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0; meip_in = 0; mtip_in = 0; msip_in = 0;
  endtask

  task automatic set_system(input logic [6:0] f7, input logic [4:0] rs2);
    opcode_6_2_in = 5'b11100; funct3_in = 3'b000; rs1_addr_in = 5'd0; rd_addr_in = 5'd0;
    funct7_in = f7; rs2_addr_in = rs2;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b0;
    clear_inputs();
    step(); step();
    chk_all("reset", 2'b00, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);

    // Release between edges: still RESET for this cycle, then OPERATING
    rst_in = 1'b1;
    #1;
    chk_all("release_reset_cycle", 2'b00, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    step();
    chk_all("first_operating", 2'b01, 0, 1, 0, 0, 0, 0, 4'd0, 0, 0);

    // ecall -> TRAP_TAKEN cause 11, then back to OPERATING
    set_system(7'd0, 5'd0);
    step();
    chk_all("ecall_trap", 2'b11, 1, 0, 1, 1, 1, 0, 4'd11, 0, 0);
    clear_inputs();
    step();
    chk_all("ecall_back", 2'b01, 0, 1, 0, 0, 0, 0, 4'd11, 0, 0);

    // Misaligned load beats pending ext/timer interrupts
    mie_in = 1; meie_in = 1; meip_in = 1; mtie_in = 1; mtip_in = 1; misaligned_load_in = 1;
    step();
    chk_all("mload_vs_int", 2'b11, 1, 0, 1, 1, 1, 0, 4'd4, 0, 1);
    // Events held through TRAP_TAKEN are ignored
    step();
    chk_all("ignored_in_trap", 2'b01, 0, 1, 0, 0, 0, 0, 4'd4, 0, 1);
    clear_inputs();

    // Software beats timer; interrupt beats mret
    mie_in = 1; mtie_in = 1; mtip_in = 1; msie_in = 1; msip_in = 1;
    set_system(7'b0011000, 5'b00010);
    step();
    chk_all("sw_int_vs_mret", 2'b11, 1, 0, 1, 1, 1, 0, 4'd3, 1, 0);
    clear_inputs();
    step();
    chk_all("sw_int_back", 2'b01, 0, 1, 0, 0, 0, 0, 4'd3, 1, 0);

    // Timer alone
    mie_in = 1; mtie_in = 1; mtip_in = 1;
    step();
    chk_all("timer_int", 2'b11, 1, 0, 1, 1, 1, 0, 4'd7, 1, 0);
    clear_inputs();
    step();

    // External beats software
    mie_in = 1; meie_in = 1; meip_in = 1; msie_in = 1; msip_in = 1;
    step();
    chk_all("ext_int", 2'b11, 1, 0, 1, 1, 1, 0, 4'd11, 1, 0);
    clear_inputs();
    step();

    // Illegal beats misaligned_instr and ecall
    illegal_instr_in = 1; misaligned_instr_in = 1; set_system(7'd0, 5'd0);
    step();
    chk_all("illegal_prio", 2'b11, 1, 0, 1, 1, 1, 0, 4'd2, 0, 0);
    clear_inputs();
    step();

    // Misaligned instr beats ebreak
    misaligned_instr_in = 1; set_system(7'd0, 5'd1);
    step();
    chk_all("minstr_vs_ebreak", 2'b11, 1, 0, 1, 1, 1, 0, 4'd0, 0, 1);
    clear_inputs();
    step();

    // ebreak beats misaligned load
    misaligned_load_in = 1; set_system(7'd0, 5'd1);
    step();
    chk_all("ebreak_vs_mload", 2'b11, 1, 0, 1, 1, 1, 0, 4'd3, 0, 0);
    clear_inputs();
    step();

    // Load beats store
    misaligned_load_in = 1; misaligned_store_in = 1;
    step();
    chk_all("mload_vs_mstore", 2'b11, 1, 0, 1, 1, 1, 0, 4'd4, 0, 1);
    clear_inputs();
    step();

    misaligned_store_in = 1;
    step();
    chk_all("mstore", 2'b11, 1, 0, 1, 1, 1, 0, 4'd6, 0, 1);
    clear_inputs();
    step();

    // mret alone -> TRAP_RETURN, cause info held
    set_system(7'b0011000, 5'b00010);
    step();
    chk_all("mret_return", 2'b10, 1, 0, 0, 0, 0, 1, 4'd6, 0, 1);
    clear_inputs();
    step();
    chk_all("mret_back", 2'b01, 0, 1, 0, 0, 0, 0, 4'd6, 0, 1);

    // Pending external with global enable off -> no trap
    meie_in = 1; meip_in = 1;
    step();
    chk_all("int_masked", 2'b01, 0, 1, 0, 0, 0, 0, 4'd6, 0, 1);
    clear_inputs();

    // mret encoding with rs1 != 0 is not SYSTEM -> no return
    set_system(7'b0011000, 5'b00010); rs1_addr_in = 5'd1;
    step();
    chk_all("mret_bad_rs1", 2'b01, 0, 1, 0, 0, 0, 0, 4'd6, 0, 1);
    clear_inputs();

    // Asynchronous reset during TRAP_TAKEN
    set_system(7'd0, 5'd0);
    step();
    chk_all("pre_async_trap", 2'b11, 1, 0, 1, 1, 1, 0, 4'd11, 0, 0);
    clear_inputs();
    rst_in = 1'b0;
    #2;
    chk_all("async_reset", 2'b00, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    step();
    rst_in = 1'b1;
    #1;
    chk_all("rerelease_cycle", 2'b00, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    step();
    chk_all("rerelease_operating", 2'b01, 0, 1, 0, 0, 0, 0, 4'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msrv32_machine_control.md
MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk_in  input  1  core clock, rising-edge active.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in  input  1 each  exception flags for the current instruction.
REQ-005 opcode_6_2_in  input  5; funct3_in  input  3; funct7_in  input  7; rs1_addr_in, rs2_addr_in, rd_addr_in  input  5 each  fields used for SYSTEM-instruction decode.
REQ-006 mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in  input  1 each  global enable, per-source enables and pending bits from the CSR file.
REQ-007 i_or_e_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out  output  1 each  trap-control strobes to the CSR file.
REQ-008 cause_out  output  4  trap cause code; pc_src_out  output  2  PC select; flush_out  output  1  pipeline flush.

Function
REQ-009 SHALL implement the FSM states RESET, OPERATING, TRAP_TAKEN and TRAP_RETURN.
REQ-010 RESET SHALL go to OPERATING unconditionally on the next clock edge.
REQ-011 TRAP_TAKEN and TRAP_RETURN SHALL each last exactly one cycle, then return to OPERATING.
REQ-012 In OPERATING, an exception or a taken interrupt SHALL move the FSM to TRAP_TAKEN; otherwise mret SHALL move it to TRAP_RETURN; otherwise it SHALL stay in OPERATING.
REQ-013 Decode: SYSTEM means opcode_6_2=11100, funct3=000, rs1=0, rd=0.
REQ-014 ecall is SYSTEM with funct7=0 and rs2=0; ebreak is SYSTEM with funct7=0 and rs2=1; mret is SYSTEM with funct7=0011000 and rs2=00010.
REQ-015 Exception priority, with cause: illegal(2) > misaligned_instr(0) > ecall(11) > ebreak(3) > misaligned_load(4) > misaligned_store(6).
REQ-016 A taken interrupt requires mie_in=1 and at least one source with both enable and pending set.
REQ-017 Interrupt priority, with cause: external(11) > software(3) > timer(7).
REQ-018 An exception SHALL win over a simultaneous interrupt; an interrupt SHALL win over a simultaneous mret.
REQ-019 cause_out, i_or_e_out (1=interrupt) and misaligned_exception_out (causes 0, 4, 6) SHALL be registered on the OPERATING->TRAP_TAKEN edge and held until the next trap.
REQ-020 OPERATING outputs: pc_src_out=01 (next PC), instret_inc_out=1, flush_out=0, all strobes 0.
REQ-021 TRAP_TAKEN outputs: set_epc_out=1, set_cause_out=1, mie_clear_out=1, pc_src_out=11 (trap address), flush_out=1, instret_inc_out=0.
REQ-022 TRAP_RETURN outputs: mie_set_out=1, pc_src_out=10 (EPC), flush_out=1, instret_inc_out=0.
REQ-023 RESET outputs: pc_src_out=00 (boot address), flush_out=1, all strobes 0.
REQ-024 Exceptions and interrupts SHALL be ignored in TRAP_TAKEN and TRAP_RETURN; interrupt inputs are level-sampled each OPERATING cycle.

Reset
REQ-025 Assertion of rst_in (low) SHALL immediately force RESET, regardless of the current state, including mid-trap.
REQ-026 During reset SHALL hold cause_out=0, i_or_e_out=0, misaligned_exception_out=0, and the RESET outputs of REQ-023.
REQ-027 Release SHALL be synchronised by the surrounding reset logic; the block SHALL leave RESET one edge after release.

Structure
REQ-028 Package msrv32_pkg SHALL hold the state encodings, the cause codes and the pc_src encodings (BOOT=00, NEXT=01, EPC=10, TRAP=11).
REQ-029 Combinational decode and priority encoding SHALL live in one sub-module, msrv32_trap_decode (outputs: trap_req, is_int, cause, is_misaligned, mret).
REQ-030 The FSM and output registers SHALL live in the top module.

Verification
REQ-031 Release reset, no events -> one cycle with pc_src=00 and flush=1, then pc_src=01 and instret_inc=1.
REQ-032 ecall in OPERATING -> next cycle TRAP_TAKEN: set_epc=1, set_cause=1, cause=11, i_or_e=0, pc_src=11, mie_clear=1; the cycle after returns to OPERATING.
REQ-033 mie=1, meie=1, meip=1, mtie=1, mtip=1, plus misaligned_load -> cause=4, i_or_e=0, misaligned_exception=1.
REQ-034 mie=1, mtie=1, mtip=1, msie=1, msip=1, plus mret -> cause=3, i_or_e=1; no TRAP_RETURN.
REQ-035 mret alone -> one cycle with mie_set=1, pc_src=10, flush=1; meip=1 with mie=0 -> stays in OPERATING.
REQ-036 rst_in driven low during TRAP_TAKEN -> outputs return to reset values without waiting for a clock edge.
